// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-word memory port between the I-cache (0) and D-cache (1).
// Define MEM_TIMEOUT_EN to add a per-beat mem_ack watchdog that aborts through an ERR state.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_req0_strobe,
    input  logic                          i_req0_rw,
    input  logic [ADDR_W-1:0]             i_req0_addr,
    input  logic [DATA_W-1:0]             i_req0_wdata,
    output logic                          o_req0_beat_vld,
    output logic                          o_req0_rdy,
    input  logic                          i_req1_strobe,
    input  logic                          i_req1_rw,
    input  logic [ADDR_W-1:0]             i_req1_addr,
    input  logic [DATA_W-1:0]             i_req1_wdata,
    output logic                          o_req1_beat_vld,
    output logic                          o_req1_rdy,
    output logic [1:0]                    o_gnt,
    output logic [$clog2(LINE_WORDS)-1:0] o_beat_idx,
    output logic [DATA_W-1:0]             o_rdata,
    output logic                          o_err,
    output logic                          o_mem_strobe,
    output logic                          o_mem_rw,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [DATA_W-1:0]             o_mem_wdata,
    input  logic                          i_mem_ack,
    input  logic [DATA_W-1:0]             i_mem_rdata
);
    localparam int BW = $clog2(LINE_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef MEM_TIMEOUT_EN
    localparam logic [1:0] S_ERR  = 2'd3;
    localparam int         WW     = $clog2(TIMEOUT + 1);
`endif

    // Reject illegal configurations at elaboration time.
    if ((LINE_WORDS < 2) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0) || (TIMEOUT < 1)) begin : g_cfg_chk
        $error("mem_bus_arbiter: LINE_WORDS must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    logic [1:0]         r_state;
    logic [BW-1:0]      r_beat_idx;
    logic               r_rr_ptr;
    logic [1:0]         r_gnt;
    logic               r_rw;
    logic [ADDR_W-BW-1:0] r_base;
`ifdef MEM_TIMEOUT_EN
    logic [WW-1:0]      r_wait;
`endif

    logic               w_any;
    logic               w_sel;
    logic               w_beat;
    logic               w_ack;
    logic               w_last;
    logic               w_end;
    logic [ADDR_W-1:0]  w_addr;

    assign w_any  = i_req0_strobe | i_req1_strobe;
    // Contention goes to rr_ptr; otherwise the lone requester wins.
    assign w_sel  = (i_req0_strobe & i_req1_strobe) ? r_rr_ptr : i_req1_strobe;
    assign w_addr = w_sel ? i_req1_addr : i_req0_addr;
    assign w_beat = (r_state == S_BEAT);
    assign w_ack  = w_beat & i_mem_ack;
    assign w_last = (r_beat_idx == BW'(LINE_WORDS - 1));
`ifdef MEM_TIMEOUT_EN
    assign w_end  = (r_state == S_DONE) | (r_state == S_ERR);
    assign o_err  = (r_state == S_ERR);
`else
    assign w_end  = (r_state == S_DONE);
    assign o_err  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_beat_idx <= '0;
            r_rr_ptr   <= 1'b0;
            r_gnt      <= 2'b00;
            r_rw       <= 1'b0;
            r_base     <= '0;
`ifdef MEM_TIMEOUT_EN
            r_wait     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_sel ? 2'b10 : 2'b01;
                        r_rw       <= w_sel ? i_req1_rw : i_req0_rw;
                        r_base     <= w_addr[ADDR_W-1:BW];
                        r_beat_idx <= '0;
                        r_state    <= S_BEAT;
`ifdef MEM_TIMEOUT_EN
                        r_wait     <= '0;
`endif
                    end
                end
                S_BEAT: begin
                    if (i_mem_ack) begin
                        if (w_last) r_state <= S_DONE;
                        else        r_beat_idx <= r_beat_idx + 1'b1;
`ifdef MEM_TIMEOUT_EN
                        r_wait <= '0;
                    end else if (r_wait == WW'(TIMEOUT - 1)) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wait <= r_wait + 1'b1;
`endif
                    end
                end
                default: begin
                    // DONE and ERR both hand priority to the requester that was not served.
                    r_rr_ptr <= r_gnt[0];
                    r_gnt    <= 2'b00;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt           = r_gnt;
    assign o_beat_idx      = r_beat_idx;
    assign o_mem_strobe    = w_beat;
    assign o_mem_rw        = w_beat & r_rw;
    assign o_mem_addr      = {r_base, r_beat_idx};
    assign o_mem_wdata     = r_gnt[1] ? i_req1_wdata : (r_gnt[0] ? i_req0_wdata : '0);
    assign o_rdata         = w_ack ? i_mem_rdata : '0;
    assign o_req0_beat_vld = w_ack & r_gnt[0];
    assign o_req1_beat_vld = w_ack & r_gnt[1];
    assign o_req0_rdy      = w_end & r_gnt[0];
    assign o_req1_rdy      = w_end & r_gnt[1];
endmodule
